qbank_monitor: RTL

QBANK_MONITOR -- requirements
Module: qbank_monitor

---
 rtl/qbank_pkg.sv | 12 +
 rtl/qbank_fifo.sv | 51 +++++
 rtl/qbank_monitor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/qbank_pkg.sv
// Shared types and constants for the flop-bank toggle monitor.
package qbank_pkg;

  localparam int LANES_DEF = 5;
  localparam int LANE_W    = $clog2(LANES_DEF);

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic              value;
  } ev_t;

endpackage

// File: rtl/qbank_fifo.sv
// Event FIFO for qbank_monitor: DEPTH entries (power of two), registered pointers,
// head entry readable without a pop.
module qbank_fifo
  import qbank_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  ev_t  push_data,
  input  logic pop,
  output ev_t  head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  ev_t         mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qbank_monitor.sv
// Monitors an asynchronous flop bank: synchronizes each lane, queues level-change events
// and optionally counts toggles per lane (counters built only with QBANK_TOGGLE_CNT_EN).
module qbank_monitor
  import qbank_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [LANES-1:0]         q_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(LANES)-1:0] ev_lane,
  output logic                     ev_value,
  output logic                     ev_ovf,
  input  logic [$clog2(LANES)-1:0] cnt_sel,
  output logic [CNT_W-1:0]         cnt_val,
  input  logic                     cnt_clear
);

  localparam int LW = $clog2(LANES);

  logic [LANES-1:0] sync1;
  logic [LANES-1:0] sync2;
  logic [LANES-1:0] prev;
  logic [LANES-1:0] pending;
  logic [LANES-1:0] change;
  logic [LANES-1:0] grant;
  logic [LANES-1:0] clr_mask;
  logic [LW-1:0]    push_lane;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             fifo_full;
  logic             fifo_empty;
  ev_t              push_ev;
  ev_t              head;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= q_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign change = sync2 ^ prev;

  // Lowest set pending bit wins the single push slot of the cycle.
  assign grant = pending & (~pending + 1'b1);

  always_comb begin
    push_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_lane = LW'(i);
      end
    end
  end

  assign push     = (|pending) && !fifo_full;
  assign clr_mask = push ? grant : '0;
  assign ovf_set  = |(change & pending & ~clr_mask);

  always_comb begin
    push_ev       = '0;
    push_ev.lane  = push_lane;
    push_ev.value = |(sync2 & grant);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pending <= '0;
      ev_ovf  <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | change;
      if (cnt_clear) begin
        ev_ovf <= 1'b0;
      end else if (ovf_set) begin
        ev_ovf <= 1'b1;
      end
    end
  end

  assign pop = ev_ready && !fifo_empty;

  qbank_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (clr),
    .push     (push),
    .push_data(push_ev),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Head fields are gated so an empty queue always presents zeros.
  assign ev_valid = !fifo_empty;
  assign ev_lane  = fifo_empty ? '0 : head.lane;
  assign ev_value = !fifo_empty && head.value;

`ifdef QBANK_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt [LANES];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < LANES; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (cnt_clear) begin
          cnt[i] <= '0;
        end else if (change[i] && (cnt[i] != {CNT_W{1'b1}})) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Selects beyond the last lane match nothing and read as zero.
  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_sel == LW'(i)) begin
        cnt_val = cnt[i];
      end
    end
  end
`else
  logic unused_cnt_sel;

  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_val        = '0;
`endif

endmodule
